// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Memory-side responder on the CPU external bus. It serves a byte-wide RAM
//   window and a memory-mapped console. Bytes written to the console data
//   register are queued in a TX FIFO, which a consumer drains through a
//   valid/ready stream. The CPU is never stalled.
//
// Ports
//   clk        system clock, rising edge
//   RST        synchronous active-high reset
//   A_BUS      CPU address bus (16)
//   RW         1 = read, 0 = write
//   D_IN       CPU write data (8)
//   D_OUT      read data, valid one cycle after the read address (8)
//   D_OE       high when D_OUT must drive the shared data bus
//   CON_VALID  TX FIFO non-empty
//   CON_BYTE   head of TX FIFO (8)
//   CON_READY  consumer accepts CON_BYTE this cycle
module cpu_bus_responder #(
  parameter logic [15:0] RAM_BASE        = 16'h8000,
  parameter int          RAM_AW          = 11,
  parameter logic [15:0] CON_DATA_ADDR   = 16'hF000,
  parameter logic [15:0] CON_STAT_ADDR   = 16'hF001,
  parameter int          FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] A_BUS,
  input  logic        RW,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        CON_VALID,
  output logic [7:0]  CON_BYTE,
  input  logic        CON_READY
);

  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  // Storage
  logic [7:0]                 r_ram  [2**RAM_AW];
  logic [7:0]                 r_fifo [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_ovf;
  logic [7:0]                 r_dout;
  logic                       r_doe;

  // Decode. If the ranges overlap, the console registers win over RAM.
  logic              w_cd_sel, w_cs_sel, w_ram_sel;
  logic [RAM_AW-1:0] w_ram_addr;

  assign w_cd_sel   = (A_BUS == CON_DATA_ADDR);
  assign w_cs_sel   = (A_BUS == CON_STAT_ADDR);
  assign w_ram_sel  = (A_BUS[15:RAM_AW] == RAM_BASE[15:RAM_AW]) && !w_cd_sel && !w_cs_sel;
  assign w_ram_addr = A_BUS[RAM_AW-1:0];

  // FIFO handshake
  logic       w_empty, w_full, w_push, w_pop, w_push_ok, w_ovf_set, w_stat_rd;
  logic [3:0] w_cnt_sat;
  logic [7:0] w_status;

  assign w_empty   = (r_count == '0);
  assign w_full    = (32'(r_count) == DEPTH);
  assign w_push    = w_cd_sel && !RW;
  assign w_pop     = !w_empty && CON_READY;
  // A pop frees the slot on the same edge, so a push while full still lands.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_stat_rd = w_cs_sel && RW;

  assign w_cnt_sat = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);
  assign w_status  = {w_cnt_sat, 1'b0, r_ovf, w_full, w_empty};

  // Bus read path: one cycle of latency, D_OUT is zero when not driving.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_dout <= 8'h00;
      r_doe  <= 1'b0;
    end else begin
      r_dout <= 8'h00;
      r_doe  <= 1'b0;
      if (RW) begin
        if (w_cd_sel) begin
          r_doe <= 1'b1;
        end else if (w_cs_sel) begin
          r_doe  <= 1'b1;
          r_dout <= w_status;
        end else if (w_ram_sel) begin
          r_doe  <= 1'b1;
          r_dout <= r_ram[w_ram_addr];
        end
      end
    end
  end

  // RAM is not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!RST && w_ram_sel && !RW)
      r_ram[w_ram_addr] <= D_IN;
  end

  always_ff @(posedge clk) begin
    if (!RST && w_push_ok)
      r_fifo[r_wr_ptr] <= D_IN;
  end

  // FIFO pointers, count and sticky overflow
  always_ff @(posedge clk) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new overflow on the same edge as a status read keeps the flag set.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_stat_rd) r_ovf <= 1'b0;
    end
  end

  assign D_OUT     = r_dout;
  assign D_OE      = r_doe;
  assign CON_VALID = !w_empty;
  assign CON_BYTE  = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] A_BUS;
  logic        RW;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        CON_VALID;
  logic [7:0]  CON_BYTE;
  logic        CON_READY;

  int checks   = 0;
  int failures = 0;

  cpu_bus_responder dut (
    .clk(clk), .RST(RST), .A_BUS(A_BUS), .RW(RW), .D_IN(D_IN),
    .D_OUT(D_OUT), .D_OE(D_OE), .CON_VALID(CON_VALID), .CON_BYTE(CON_BYTE),
    .CON_READY(CON_READY)
  );

  always #5 clk = ~clk;

  // One bus cycle: present the transaction, clock it, and settle 1 time unit later.
  task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
    A_BUS = a; RW = rw; D_IN = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(16'h0000, 1'b1, 8'h00);
  endtask

  task automatic test_reset();
    RST = 1'b1; CON_READY = 1'b0;
    idle(); idle();
    checks++; if (D_OE !== 1'b0) begin failures++; $display("FAIL reset_doe got=%b exp=0", D_OE); end
    checks++; if (D_OUT !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", D_OUT); end
    checks++; if (CON_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", CON_VALID); end
    RST = 1'b0;
    cyc(16'hF001, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h01 || D_OE !== 1'b1) begin failures++; $display("FAIL reset_status got=%h/%b exp=01/1", D_OUT, D_OE); end
    idle();
    checks++; if (D_OE !== 1'b0) begin failures++; $display("FAIL idle_unmapped_doe got=%b exp=0", D_OE); end
  endtask

  task automatic test_ram();
    cyc(16'h8000, 1'b0, 8'hA5);
    checks++; if (D_OE !== 1'b0) begin failures++; $display("FAIL ram_write_doe got=%b exp=0", D_OE); end
    cyc(16'h87FF, 1'b0, 8'h3C);
    cyc(16'h8000, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'hA5 || D_OE !== 1'b1) begin failures++; $display("FAIL ram_rd_8000 got=%h/%b exp=a5/1", D_OUT, D_OE); end
    cyc(16'h87FF, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h3C || D_OE !== 1'b1) begin failures++; $display("FAIL ram_rd_87ff got=%h/%b exp=3c/1", D_OUT, D_OE); end
    cyc(16'h8800, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h00 || D_OE !== 1'b0) begin failures++; $display("FAIL ram_rd_8800 got=%h/%b exp=00/0", D_OUT, D_OE); end
    // Write to unmapped mirror address must not alias into RAM
    cyc(16'h0000, 1'b0, 8'hFF);
    cyc(16'h8000, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'hA5) begin failures++; $display("FAIL ram_no_alias got=%h exp=a5", D_OUT); end
    // Console data register read returns zero with D_OE high
    cyc(16'hF000, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h00 || D_OE !== 1'b1) begin failures++; $display("FAIL con_data_rd got=%h/%b exp=00/1", D_OUT, D_OE); end
  endtask

  task automatic test_console();
    CON_READY = 1'b0;
    cyc(16'hF000, 1'b0, 8'h48);
    cyc(16'hF000, 1'b0, 8'h69);
    checks++; if (CON_VALID !== 1'b1 || CON_BYTE !== 8'h48) begin failures++; $display("FAIL con_head got=%b/%h exp=1/48", CON_VALID, CON_BYTE); end
    cyc(16'hF001, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h20) begin failures++; $display("FAIL con_status got=%h exp=20", D_OUT); end
    CON_READY = 1'b1;
    idle();
    checks++; if (CON_VALID !== 1'b1 || CON_BYTE !== 8'h69) begin failures++; $display("FAIL con_second got=%b/%h exp=1/69", CON_VALID, CON_BYTE); end
    idle();
    checks++; if (CON_VALID !== 1'b0) begin failures++; $display("FAIL con_drained got=%b exp=0", CON_VALID); end
    // Push + pop while empty: only the push happens
    cyc(16'hF000, 1'b0, 8'h55);
    checks++; if (CON_VALID !== 1'b1 || CON_BYTE !== 8'h55) begin failures++; $display("FAIL empty_pushpop got=%b/%h exp=1/55", CON_VALID, CON_BYTE); end
    CON_READY = 1'b0;
    cyc(16'hF001, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h10) begin failures++; $display("FAIL empty_pushpop_status got=%h exp=10", D_OUT); end
    CON_READY = 1'b1;
    idle();
    checks++; if (CON_VALID !== 1'b0) begin failures++; $display("FAIL empty_pushpop_drain got=%b exp=0", CON_VALID); end
    CON_READY = 1'b0;
  endtask

  task automatic test_overflow();
    CON_READY = 1'b0;
    for (int i = 0; i < 9; i++) cyc(16'hF000, 1'b0, 8'h10 + 8'(i));
    cyc(16'hF001, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h86) begin failures++; $display("FAIL ovf_status got=%h exp=86", D_OUT); end
    cyc(16'hF001, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h82) begin failures++; $display("FAIL ovf_cleared got=%h exp=82", D_OUT); end
    CON_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (CON_VALID !== 1'b1 || CON_BYTE !== 8'h10 + 8'(i)) begin
        failures++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, CON_VALID, CON_BYTE, 8'h10 + 8'(i));
      end
      idle();
    end
    checks++; if (CON_VALID !== 1'b0) begin failures++; $display("FAIL ovf_ninth_lost got=%b exp=0", CON_VALID); end
    CON_READY = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_q [$];
    CON_READY = 1'b0;
    for (int i = 0; i < 8; i++) cyc(16'hF000, 1'b0, 8'h20 + 8'(i));
    CON_READY = 1'b1;
    cyc(16'hF000, 1'b0, 8'h99);
    CON_READY = 1'b0;
    cyc(16'hF001, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h82) begin failures++; $display("FAIL full_pushpop_status got=%h exp=82", D_OUT); end
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h20 + 8'(i));
    exp_q.push_back(8'h99);
    CON_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (CON_VALID !== 1'b1 || CON_BYTE !== exp_q[i]) begin
        failures++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, CON_VALID, CON_BYTE, exp_q[i]);
      end
      idle();
    end
    checks++; if (CON_VALID !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", CON_VALID); end
    CON_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    CON_READY = 1'b0;
    cyc(16'h8123, 1'b0, 8'h77);
    for (int i = 0; i < 3; i++) cyc(16'hF000, 1'b0, 8'hC0 + 8'(i));
    cyc(16'hF001, 1'b1, 8'h00);
    // Reset asserted for one cycle while a RAM write is presented: the write is ignored
    RST = 1'b1;
    cyc(16'h8123, 1'b0, 8'hEE);
    RST = 1'b0;
    checks++; if (CON_VALID !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", CON_VALID); end
    checks++; if (D_OE !== 1'b0 || D_OUT !== 8'h00) begin failures++; $display("FAIL mid_reset_bus got=%h/%b exp=00/0", D_OUT, D_OE); end
    cyc(16'hF001, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h01) begin failures++; $display("FAIL mid_reset_status got=%h exp=01", D_OUT); end
    cyc(16'h8123, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'h77) begin failures++; $display("FAIL mid_reset_ram got=%h exp=77", D_OUT); end
    cyc(16'h8000, 1'b1, 8'h00);
    checks++; if (D_OUT !== 8'hA5) begin failures++; $display("FAIL mid_reset_ram_old got=%h exp=a5", D_OUT); end
  endtask

  initial begin
    RST = 1'b1; A_BUS = 16'h0000; RW = 1'b1; D_IN = 8'h00; CON_READY = 1'b0;
    test_reset();
    test_ram();
    test_console();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-side responder for the CPU's external address/data bus: answers CPU reads and writes as a RAM window plus a memory-mapped console port.
- Sits beside program_rom on A_BUS/D_BUS, decoding its own address ranges only.
- Console writes enter a TX FIFO that a bench or host drains through a valid/ready stream.
- Gives CPU programs writable memory and an observable output channel for self-checking tests.

Parameters:
- RAM_BASE, 16'h8000, base address of RAM window; must be aligned to 2^RAM_AW.
- RAM_AW, 11, RAM address width; window is 2^RAM_AW bytes.
- CON_DATA_ADDR, 16'hF000, console data register: write pushes, read returns 8'h00.
- CON_STAT_ADDR, 16'hF001, console status register, read-only.
- FIFO_DEPTH_LOG2, 3, TX FIFO depth = 2^FIFO_DEPTH_LOG2 entries (default 8).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- A_BUS  in  16  CPU address bus.
- RW  in  1  CPU read/write: 1 = read, 0 = write.
- D_IN  in  8  CPU write data, meaningful when RW=0.
- D_OUT  out  8  read data returned to CPU.
- D_OE  out  1  high when D_OUT must drive the shared data bus.
- CON_VALID  out  1  TX FIFO non-empty.
- CON_BYTE  out  8  head of TX FIFO.
- CON_READY  in  1  consumer accepts CON_BYTE this cycle.

Behaviour:
- Address decode, combinational on A_BUS:
  - RAM_SEL = A_BUS[15:RAM_AW] == RAM_BASE[15:RAM_AW].
  - CD_SEL = A_BUS == CON_DATA_ADDR.
  - CS_SEL = A_BUS == CON_STAT_ADDR.
  - Console addresses take priority over RAM if ranges overlap.
  - Any other address is unmapped.
- Reads, latency 1: the address and RW=1 presented in cycle N produce D_OUT/D_OE in cycle N+1.
  - D_OE=1 only for a mapped read; otherwise D_OE=0 and D_OUT=8'h00.
- RAM read returns the byte at A_BUS[RAM_AW-1:0] as stored before any write in the same cycle (read-before-write).
- Writes, RW=0, committed at the rising edge of cycle N:
  - RAM write stores D_IN.
  - CD_SEL write pushes D_IN into the FIFO.
  - Writes to CS_SEL or unmapped addresses are ignored.
  - D_OE=0 in cycle N+1 after any write.
- Status byte layout:
  - [0] empty.
  - [1] full.
  - [2] overflow (sticky).
  - [3] 0.
  - [7:4] entry count, saturated at 15.
- A status read returns the pre-edge value and clears overflow at that edge. If an overflow event occurs on the same edge, set wins and overflow stays 1.
- TX FIFO:
  - Circular buffer; read/write pointers are FIFO_DEPTH_LOG2 bits wide and wrap modulo depth.
  - count is FIFO_DEPTH_LOG2+1 bits.
  - Push when CD_SEL & !RW. Pop when CON_VALID & CON_READY.
  - CON_VALID = (count != 0). CON_BYTE = mem[rd_ptr], combinational from registered state.
- FIFO boundary cases:
  - Push while full with no pop: byte dropped, overflow set, pointers unchanged.
  - Push + pop while full: both occur, count unchanged, no overflow.
  - Push + pop while empty: push only (CON_VALID was 0); count becomes 1.
  - Pop while empty is impossible, since CON_VALID=0.
- Reset, synchronous, any cycle including mid-transfer:
  - D_OUT=8'h00, D_OE=0, CON_VALID=0, count=0, pointers=0, overflow=0.
  - Pending FIFO data is discarded. RAM contents are not reset.
  - While RST=1, bus writes are ignored.
- No wait states: the CPU is never stalled.

Test Plan:
- Reset then idle: after RST=1 for 2 cycles -> D_OE=0, D_OUT=00, CON_VALID=0; status read at F001 -> 8'h01 one cycle later, D_OE=1.
- RAM write/read: write 8'hA5 @8000 and 8'h3C @87FF, then read both -> A5 then 3C, each 1 cycle after address, D_OE=1; read @8800 (unmapped) -> D_OE=0, D_OUT=00.
- Console stream: CON_READY=0, write 'H','i' to F000 -> CON_VALID=1, CON_BYTE=8'h48, status=8'h20; raise CON_READY -> 48 then 69 consumed on successive cycles, then CON_VALID=0.
- Overflow: CON_READY=0, 9 writes to F000 -> status 8'h86. Read status again -> 8'h82. The first 8 bytes drain in order; the 9th is lost.
- Full push+pop: fill 8 entries, write F000 with CON_READY=1 in the same cycle -> count stays 8, overflow=0, the new byte appears last in drain order.
- Reset mid-operation: 3 bytes queued, RST pulsed 1 cycle -> CON_VALID=0, status=8'h01; RAM byte written before reset still reads back.
